// File: rtl/sha256_msg_schedule_if.sv
// Stream interface for the SHA-256 message scheduler:
// message words flow in, expanded schedule words flow out.
interface sha256_msg_schedule_if #(
  parameter int WORDSIZE = 32
);
  logic                in_valid;
  logic                in_ready;
  logic [WORDSIZE-1:0] in_data;
  logic                out_valid;
  logic                out_ready;
  logic [WORDSIZE-1:0] out_data;
  logic [5:0]          out_index;
  logic                out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_index, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_index, out_last
  );
endinterface

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule generator: loads W0..W15 into a 16-word window,
// then shifts the window once per output handshake while appending W(t+16).
module sha256_msg_schedule #(
  parameter int WORDSIZE = 32,
  parameter int ROUNDS   = 64
) (
  input logic                  clk,
  input logic                  rst_n,
  sha256_msg_schedule_if.slave bus
);

  typedef enum logic [0:0] {
    LOAD = 1'b0,
    EMIT = 1'b1
  } state_t;

  localparam logic [5:0] LAST_IDX = 6'(ROUNDS - 1);

  function automatic logic [WORDSIZE-1:0] rotr(input logic [WORDSIZE-1:0] x, input int n);
    return (x >> n) | (x << (WORDSIZE - n));
  endfunction

  function automatic logic [WORDSIZE-1:0] small_sigma0(input logic [WORDSIZE-1:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [WORDSIZE-1:0] small_sigma1(input logic [WORDSIZE-1:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  state_t              state_r;
  state_t              state_nx_s;
  logic [3:0]          ld_cnt_r;
  logic [5:0]          t_cnt_r;
  logic                out_last_r;
  logic [WORDSIZE-1:0] win_r [16];
  logic                in_hs_s;
  logic                out_hs_s;
  logic [WORDSIZE-1:0] next_word_s;

  assign in_hs_s  = bus.in_valid  && (state_r == LOAD);
  assign out_hs_s = bus.out_ready && (state_r == EMIT);

  // Single 4-input modular adder producing W(t+16) from the current window.
  assign next_word_s = small_sigma1(win_r[14]) + win_r[9] + small_sigma0(win_r[1]) + win_r[0];

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= LOAD;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state decode: LOAD ends on the 16th word, EMIT ends on the final round handshake.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      LOAD: begin
        if (in_hs_s && (ld_cnt_r == 4'd15)) begin
          state_nx_s = EMIT;
        end else begin
          state_nx_s = LOAD;
        end
      end
      EMIT: begin
        if (out_hs_s && (t_cnt_r == LAST_IDX)) begin
          state_nx_s = LOAD;
        end else begin
          state_nx_s = EMIT;
        end
      end
      default: begin
        state_nx_s = LOAD;
      end
    endcase
  end

  // Load and round counters plus the registered last-word flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ld_cnt_r   <= 4'd0;
      t_cnt_r    <= 6'd0;
      out_last_r <= 1'b0;
    end else begin
      // ld_cnt wraps 15 -> 0 on the final load word, ready for the next block.
      if (in_hs_s) begin
        ld_cnt_r <= ld_cnt_r + 4'd1;
      end else begin
        ld_cnt_r <= ld_cnt_r;
      end
      if (state_r == LOAD) begin
        t_cnt_r    <= 6'd0;
        out_last_r <= 1'b0;
      end else if (out_hs_s) begin
        if (t_cnt_r == LAST_IDX) begin
          t_cnt_r    <= 6'd0;
          out_last_r <= 1'b0;
        end else begin
          t_cnt_r    <= t_cnt_r + 6'd1;
          out_last_r <= ((t_cnt_r + 6'd1) == LAST_IDX);
        end
      end else begin
        t_cnt_r    <= t_cnt_r;
        out_last_r <= out_last_r;
      end
    end
  end

  // Message window: indexed writes while loading, shift-and-append while emitting.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin
        win_r[i] <= '0;
      end
    end else if (in_hs_s) begin
      win_r[ld_cnt_r] <= bus.in_data;
    end else if (out_hs_s) begin
      for (int i = 0; i < 15; i++) begin
        win_r[i] <= win_r[i+1];
      end
      win_r[15] <= next_word_s;
    end else begin
      for (int i = 0; i < 16; i++) begin
        win_r[i] <= win_r[i];
      end
    end
  end

  assign bus.in_ready  = (state_r == LOAD);
  assign bus.out_valid = (state_r == EMIT);
  assign bus.out_data  = win_r[0];
  assign bus.out_index = t_cnt_r;
  assign bus.out_last  = out_last_r;

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Scoreboard bench for sha256_msg_schedule: a direct-formula schedule model feeds
// expected-word queues that independent monitors drain for a 64- and a 16-round build.
module tb_sha256_msg_schedule;

  typedef logic [31:0] blk_t [16];
  typedef logic [31:0] sched_t [64];
  typedef struct packed {
    logic [5:0]  idx;
    logic [31:0] data;
    logic        last;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sha256_msg_schedule_if #(.WORDSIZE(32)) bus ();
  sha256_msg_schedule_if #(.WORDSIZE(32)) bus16 ();

  sha256_msg_schedule #(.WORDSIZE(32), .ROUNDS(64)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  sha256_msg_schedule #(.WORDSIZE(32), .ROUNDS(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .bus(bus16)
  );

  // The 16-round build sees exactly the words the main build accepts.
  assign bus16.in_valid  = bus.in_valid && bus.in_ready;
  assign bus16.in_data   = bus.in_data;
  assign bus16.out_ready = 1'b1;

  int   checks = 0;
  int   failures = 0;
  int   ready_pct = 100;
  int   gap_max = 0;
  exp_t q[$];
  exp_t q16[$];
  blk_t abc_blk, zero_blk, ones_blk, rnd_blk;

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    logic [63:0] d;
    d = {x, x} >> n;
    return d[31:0];
  endfunction

  function automatic logic [31:0] s0(input logic [31:0] x);
    return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] s1(input logic [31:0] x);
    return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
  endfunction

  task automatic build_sched(input blk_t b, output sched_t w);
    for (int t = 0; t < 16; t++) w[t] = b[t];
    for (int t = 16; t < 64; t++) w[t] = s1(w[t-2]) + w[t-7] + s0(w[t-15]) + w[t-16];
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  task automatic abort_timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=event at %0t", name, $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  task automatic push_expected(input sched_t w);
    for (int t = 0; t < 64; t++) q.push_back({6'(t), w[t], (t == 63)});
    for (int t = 0; t < 16; t++) q16.push_back({6'(t), w[t], (t == 15)});
  endtask

  // Drives nwords input words with optional random gaps; returns at posedge+1 after the last handshake.
  task automatic send_words(input blk_t b, input int nwords);
    for (int i = 0; i < nwords; i++) begin
      int g;
      int budget;
      bit hs;
      g = (gap_max > 0) ? $urandom_range(gap_max) : 0;
      for (int k = 0; k < g; k++) begin
        bus.in_valid = 1'b0;
        bus.in_data  = $urandom;
        @(posedge clk); #1;
      end
      bus.in_valid = 1'b1;
      bus.in_data  = b[i];
      hs = 1'b0;
      budget = 0;
      while (!hs) begin
        @(negedge clk);
        hs = bus.in_ready;
        @(posedge clk); #1;
        budget++;
        if (!hs && budget > 400) abort_timeout("in_handshake");
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic send_block(input blk_t b, input sched_t w);
    push_expected(w);
    send_words(b, 16);
    @(negedge clk);
    check("first_out_latency", {63'd0, bus.out_valid}, 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic wait_drain();
    int budget;
    budget = 0;
    while (q.size() != 0 || q16.size() != 0) begin
      @(posedge clk); #1;
      budget++;
      if (budget > 2000) abort_timeout("drain");
    end
    @(posedge clk); #1;
  endtask

  // Called at posedge+1: holds reset across exactly one edge and checks the state after it.
  task automatic pulse_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    q.delete();
    q16.delete();
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
    check("rst_out_index", {58'd0, bus.out_index}, 64'd0);
    @(posedge clk); #1;
  endtask

  // Random consumer throttling.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      bus.out_ready = ($urandom_range(99) < ready_pct);
    end
  end

  // Main scoreboard monitor: word order, stall stability, ready/valid exclusivity, post-last bubble.
  initial begin
    bit   stall;
    bit   bubble;
    exp_t held;
    exp_t cur;
    exp_t e;
    stall  = 1'b0;
    bubble = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall  = 1'b0;
        bubble = 1'b0;
      end else begin
        cur = {bus.out_index, bus.out_data, bus.out_last};
        check("ready_valid_exclusive", {63'd0, bus.in_ready && bus.out_valid}, 64'd0);
        if (bubble) begin
          check("in_ready_after_last", {62'd0, bus.in_ready, bus.out_valid}, 64'd2);
          bubble = 1'b0;
        end
        if (stall) begin
          check("stall_hold", {24'd0, bus.out_valid, cur}, {24'd0, 1'b1, held});
          stall = 1'b0;
        end
        if (bus.out_valid) begin
          if (bus.out_ready) begin
            if (q.size() == 0) begin
              check("unexpected_output", {25'd0, cur}, 64'd0 - 64'd1);
            end else begin
              e = q.pop_front();
              check("out_word", {25'd0, cur}, {25'd0, e});
              bubble = e.last;
            end
          end else begin
            stall = 1'b1;
            held  = cur;
          end
        end
      end
    end
  end

  // Monitor for the 16-round build.
  initial begin
    exp_t cur;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus16.out_valid) begin
        cur = {bus16.out_index, bus16.out_data, bus16.out_last};
        if (q16.size() == 0) begin
          check("r16_unexpected_output", {25'd0, cur}, 64'd0 - 64'd1);
        end else begin
          e = q16.pop_front();
          check("r16_out_word", {25'd0, cur}, {25'd0, e});
        end
      end
    end
  end

  initial begin
    #500000;
    abort_timeout("watchdog");
  end

  initial begin
    sched_t w;
    int     budget;
    bus.in_valid = 1'b0;
    bus.in_data  = 32'd0;
    for (int i = 0; i < 16; i++) begin
      abc_blk[i]  = 32'd0;
      zero_blk[i] = 32'd0;
      ones_blk[i] = 32'hFFFF_FFFF;
      rnd_blk[i]  = $urandom;
    end
    abc_blk[0]  = 32'h6162_6380;
    abc_blk[15] = 32'h0000_0018;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_in_ready", {63'd0, bus.in_ready}, 64'd1);
    check("reset_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("reset_out_index", {58'd0, bus.out_index}, 64'd0);
    check("reset_out_data", {32'd0, bus.out_data}, 64'd0);
    check("reset_out_last", {63'd0, bus.out_last}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // "abc" block, unthrottled; published W16..W19 used directly.
    build_sched(abc_blk, w);
    w[16] = 32'h6162_6380;
    w[17] = 32'h000F_0000;
    w[18] = 32'h7DA8_6405;
    w[19] = 32'h6000_03C6;
    send_block(abc_blk, w);
    wait_drain();

    for (int t = 0; t < 64; t++) w[t] = 32'd0;
    send_block(zero_blk, w);
    wait_drain();

    // Throttled output and gappy input on the "abc" block.
    ready_pct = 70;
    gap_max   = 3;
    build_sched(abc_blk, w);
    send_block(abc_blk, w);
    wait_drain();

    // Back-to-back blocks.
    ready_pct = 100;
    gap_max   = 0;
    build_sched(abc_blk, w);
    send_block(abc_blk, w);
    build_sched(ones_blk, w);
    send_block(ones_blk, w);
    wait_drain();

    // Reset after 8 loaded words.
    send_words(abc_blk, 8);
    pulse_reset();

    // Reset while emitting index 30.
    build_sched(abc_blk, w);
    send_block(abc_blk, w);
    budget = 0;
    do begin
      @(negedge clk);
      budget++;
      if (budget > 500) abort_timeout("reach_index_30");
    end while (!(bus.out_valid && bus.out_index == 6'd30));
    @(posedge clk); #1;
    pulse_reset();

    // Fresh block after the aborted ones.
    build_sched(abc_blk, w);
    send_block(abc_blk, w);
    wait_drain();

    // Random block, throttled.
    ready_pct = 70;
    gap_max   = 2;
    build_sched(rnd_blk, w);
    send_block(rnd_blk, w);
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
